// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of a single RAM slave.
// Round-robin on ties, grants held for the whole cycle, out-of-window accesses answered with err.
module wb_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [31:0]           iwbm_addr,
    input  logic                  iwbm_cyc,
    input  logic                  iwbm_stb,
    input  logic [2:0]            iwbm_cti,
    input  logic [1:0]            iwbm_bte,
    output logic [31:0]           iwbm_dat_r,
    output logic                  iwbm_ack,
    output logic                  iwbm_err,

    input  logic [31:0]           dwbm_addr,
    input  logic [31:0]           dwbm_dat_w,
    input  logic [3:0]            dwbm_sel,
    input  logic                  dwbm_cyc,
    input  logic                  dwbm_stb,
    input  logic [2:0]            dwbm_cti,
    input  logic [1:0]            dwbm_bte,
    input  logic                  dwbm_we,
    output logic [31:0]           dwbm_dat_r,
    output logic                  dwbm_ack,
    output logic                  dwbm_err,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_dat_w,
    output logic [3:0]            ram_sel,
    output logic                  ram_cyc,
    output logic                  ram_stb,
    output logic [2:0]            ram_cti,
    output logic [1:0]            ram_bte,
    output logic                  ram_we,
    input  logic [31:0]           ram_dat_r,
    input  logic                  ram_ack
);

    localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   prio_d;
    logic   i_err;
    logic   d_err;
    logic   gnt_i;
    logic   gnt_d;
    logic   i_bad;
    logic   d_bad;

    // Reset gates the grant immediately so the RAM sees no cycle while rst is low.
    assign gnt_i = (state == GNT_I) && rst;
    assign gnt_d = (state == GNT_D) && rst;

    assign i_bad = (iwbm_addr >> TAG_LSB) != (BASE_ADDR >> TAG_LSB);
    assign d_bad = (dwbm_addr >> TAG_LSB) != (BASE_ADDR >> TAG_LSB);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            prio_d <= 1'b1;
            i_err  <= 1'b0;
            d_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == GNT_D) begin
                prio_d <= 1'b0;
            end else if (state == IDLE && state_next == GNT_I) begin
                prio_d <= 1'b1;
            end
            // Error pulses alternate while stb is held and vanish once the grant ends.
            i_err <= gnt_i && iwbm_cyc && iwbm_stb && i_bad && !i_err;
            d_err <= gnt_d && dwbm_cyc && dwbm_stb && d_bad && !d_err;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (iwbm_cyc && dwbm_cyc) begin
                    state_next = prio_d ? GNT_D : GNT_I;
                end else if (dwbm_cyc) begin
                    state_next = GNT_D;
                end else if (iwbm_cyc) begin
                    state_next = GNT_I;
                end
            end
            GNT_I:   state_next = iwbm_cyc ? GNT_I : IDLE;
            GNT_D:   state_next = dwbm_cyc ? GNT_D : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational mux onto the RAM port and back to the owning master.
    always_comb begin
        ram_addr   = '0;
        ram_dat_w  = '0;
        ram_sel    = '0;
        ram_cyc    = 1'b0;
        ram_stb    = 1'b0;
        ram_cti    = '0;
        ram_bte    = '0;
        ram_we     = 1'b0;
        iwbm_dat_r = '0;
        iwbm_ack   = 1'b0;
        dwbm_dat_r = '0;
        dwbm_ack   = 1'b0;
        if (gnt_i) begin
            ram_addr   = iwbm_addr[TAG_LSB-1:2];
            ram_sel    = 4'hF;
            ram_cyc    = iwbm_cyc;
            ram_stb    = iwbm_stb && !i_bad;
            ram_cti    = iwbm_cti;
            ram_bte    = iwbm_bte;
            iwbm_dat_r = ram_dat_r;
            iwbm_ack   = ram_ack && iwbm_cyc && !i_bad;
        end else if (gnt_d) begin
            ram_addr   = dwbm_addr[TAG_LSB-1:2];
            ram_dat_w  = dwbm_dat_w;
            ram_sel    = dwbm_sel;
            ram_cyc    = dwbm_cyc;
            ram_stb    = dwbm_stb && !d_bad;
            ram_cti    = dwbm_cti;
            ram_bte    = dwbm_bte;
            ram_we     = dwbm_we;
            dwbm_dat_r = ram_dat_r;
            dwbm_ack   = ram_ack && dwbm_cyc && !d_bad;
        end
    end

    assign iwbm_err = i_err && rst;
    assign dwbm_err = d_err && rst;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: arbitration order, bursts, bad-address errors and reset abort.
module tb_wb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iwbm_addr;
    logic        iwbm_cyc, iwbm_stb;
    logic [2:0]  iwbm_cti;
    logic [1:0]  iwbm_bte;
    logic [31:0] iwbm_dat_r;
    logic        iwbm_ack, iwbm_err;
    logic [31:0] dwbm_addr, dwbm_dat_w;
    logic [3:0]  dwbm_sel;
    logic        dwbm_cyc, dwbm_stb;
    logic [2:0]  dwbm_cti;
    logic [1:0]  dwbm_bte;
    logic        dwbm_we;
    logic [31:0] dwbm_dat_r;
    logic        dwbm_ack, dwbm_err;
    logic [19:0] ram_addr;
    logic [31:0] ram_dat_w;
    logic [3:0]  ram_sel;
    logic        ram_cyc, ram_stb;
    logic [2:0]  ram_cti;
    logic [1:0]  ram_bte;
    logic        ram_we;
    logic [31:0] ram_dat_r;
    logic        ram_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter #(.ADDR_WIDTH(20), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .iwbm_addr(iwbm_addr), .iwbm_cyc(iwbm_cyc), .iwbm_stb(iwbm_stb),
        .iwbm_cti(iwbm_cti), .iwbm_bte(iwbm_bte), .iwbm_dat_r(iwbm_dat_r),
        .iwbm_ack(iwbm_ack), .iwbm_err(iwbm_err),
        .dwbm_addr(dwbm_addr), .dwbm_dat_w(dwbm_dat_w), .dwbm_sel(dwbm_sel),
        .dwbm_cyc(dwbm_cyc), .dwbm_stb(dwbm_stb), .dwbm_cti(dwbm_cti),
        .dwbm_bte(dwbm_bte), .dwbm_we(dwbm_we), .dwbm_dat_r(dwbm_dat_r),
        .dwbm_ack(dwbm_ack), .dwbm_err(dwbm_err),
        .ram_addr(ram_addr), .ram_dat_w(ram_dat_w), .ram_sel(ram_sel),
        .ram_cyc(ram_cyc), .ram_stb(ram_stb), .ram_cti(ram_cti),
        .ram_bte(ram_bte), .ram_we(ram_we), .ram_dat_r(ram_dat_r),
        .ram_ack(ram_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        iwbm_addr = '0; iwbm_cyc = 0; iwbm_stb = 0; iwbm_cti = '0; iwbm_bte = '0;
        dwbm_addr = '0; dwbm_dat_w = '0; dwbm_sel = '0; dwbm_cyc = 0; dwbm_stb = 0;
        dwbm_cti = '0; dwbm_bte = '0; dwbm_we = 0;
        ram_dat_r = '0; ram_ack = 0;

        // Reset state
        tick();
        tick();
        chk("rst_ram_cyc", 32'(ram_cyc), 32'd0);
        chk("rst_ram_stb", 32'(ram_stb), 32'd0);
        chk("rst_acks", {30'd0, iwbm_ack, dwbm_ack}, 32'd0);
        chk("rst_errs", {30'd0, iwbm_err, dwbm_err}, 32'd0);
        rst = 1'b1;
        #1;

        // Single data read: grant one cycle after request
        dwbm_addr = 32'h0000_0010; dwbm_sel = 4'h3; dwbm_cyc = 1; dwbm_stb = 1;
        #1;
        chk("single_pre_grant_cyc", 32'(ram_cyc), 32'd0);
        tick();
        chk("single_ram_cyc", 32'(ram_cyc), 32'd1);
        chk("single_ram_stb", 32'(ram_stb), 32'd1);
        chk("single_ram_addr", 32'(ram_addr), 32'h4);
        chk("single_ram_sel", 32'(ram_sel), 32'h3);
        ram_ack = 1; ram_dat_r = 32'hDEAD_BEEF;
        #1;
        chk("single_dwbm_ack", 32'(dwbm_ack), 32'd1);
        chk("single_dwbm_dat", dwbm_dat_r, 32'hDEAD_BEEF);
        chk("single_iwbm_ack", 32'(iwbm_ack), 32'd0);
        tick();
        ram_ack = 0; dwbm_cyc = 0; dwbm_stb = 0;
        tick();
        chk("single_release", 32'(ram_cyc), 32'd0);

        // Tie right after reset: data first, then one idle cycle, then instruction
        do_reset();
        dwbm_addr = 32'h0000_0020; dwbm_cyc = 1; dwbm_stb = 1;
        iwbm_addr = 32'h0000_0100; iwbm_cyc = 1; iwbm_stb = 1; iwbm_cti = 3'b010;
        tick();
        chk("tie_d_first_addr", 32'(ram_addr), 32'h8);
        ram_ack = 1;
        #1;
        chk("tie_iwbm_ack_blocked", 32'(iwbm_ack), 32'd0);
        chk("tie_dwbm_ack", 32'(dwbm_ack), 32'd1);
        ram_ack = 0; dwbm_cyc = 0; dwbm_stb = 0;
        tick();
        chk("tie_idle_gap", 32'(ram_cyc), 32'd0);

        // Instruction burst of 4 beats; data master requests meanwhile and must wait
        dwbm_addr = 32'h0000_0040; dwbm_dat_w = 32'hCAFE_0001; dwbm_sel = 4'h2;
        dwbm_we = 1; dwbm_cyc = 1; dwbm_stb = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            iwbm_addr = 32'h0000_0100 + 32'(4 * k);
            iwbm_cti  = (k == 3) ? 3'b111 : 3'b010;
            ram_ack = 1; ram_dat_r = 32'h1000 + 32'(k);
            #1;
            chk("burst_iwbm_ack", 32'(iwbm_ack), 32'd1);
            chk("burst_iwbm_dat", iwbm_dat_r, 32'h1000 + 32'(k));
            chk("burst_dwbm_ack", 32'(dwbm_ack), 32'd0);
            chk("burst_ram_addr", 32'(ram_addr), 32'h40 + 32'(k));
            chk("burst_we_sel_dw", {27'd0, ram_we, ram_sel}, 32'h0F);
            chk("burst_dat_w", ram_dat_w, 32'd0);
            chk("burst_cti", 32'(ram_cti), (k == 3) ? 32'd7 : 32'd2);
            tick();
        end
        ram_ack = 0; iwbm_cyc = 0; iwbm_stb = 0; iwbm_cti = '0;
        tick();
        chk("burst_idle_gap", 32'(ram_cyc), 32'd0);
        tick();
        chk("waiting_d_grant_cyc", 32'(ram_cyc), 32'd1);
        chk("waiting_d_we", 32'(ram_we), 32'd1);
        chk("waiting_d_sel", 32'(ram_sel), 32'h2);
        chk("waiting_d_dat_w", ram_dat_w, 32'hCAFE_0001);
        chk("waiting_d_addr", 32'(ram_addr), 32'h10);
        dwbm_cyc = 0; dwbm_stb = 0; dwbm_we = 0;
        tick();

        // Bad address: stb suppressed, err alternates, no ack
        dwbm_addr = 32'h0040_0000; dwbm_cyc = 1; dwbm_stb = 1;
        tick();
        ram_ack = 1;
        #1;
        chk("bad_ram_cyc", 32'(ram_cyc), 32'd1);
        chk("bad_ram_stb", 32'(ram_stb), 32'd0);
        chk("bad_err_0", 32'(dwbm_err), 32'd0);
        chk("bad_no_ack", 32'(dwbm_ack), 32'd0);
        ram_ack = 0;
        tick();
        chk("bad_err_1", 32'(dwbm_err), 32'd1);
        chk("bad_iwbm_err", 32'(iwbm_err), 32'd0);
        tick();
        chk("bad_err_2", 32'(dwbm_err), 32'd0);
        tick();
        chk("bad_err_3", 32'(dwbm_err), 32'd1);
        dwbm_cyc = 0; dwbm_stb = 0;
        tick();
        chk("bad_err_cleared", 32'(dwbm_err), 32'd0);
        iwbm_addr = 32'h0000_0200; iwbm_cyc = 1; iwbm_stb = 1;
        tick();
        chk("next_grant_stb", 32'(ram_stb), 32'd1);
        chk("next_grant_addr", 32'(ram_addr), 32'h80);
        tick();
        chk("no_err_leak", {30'd0, iwbm_err, dwbm_err}, 32'd0);
        iwbm_cyc = 0; iwbm_stb = 0;
        tick();

        // Reset during a data burst aborts the grant; data wins the re-arbitration
        dwbm_addr = 32'h0000_0000; dwbm_cti = 3'b010; dwbm_cyc = 1; dwbm_stb = 1;
        tick();
        ram_ack = 1;
        tick();
        dwbm_addr = 32'h0000_0004;
        rst = 1'b0;
        iwbm_addr = 32'h0000_0300; iwbm_cyc = 1; iwbm_stb = 1;
        #1;
        chk("rst_mid_ack", {30'd0, iwbm_ack, dwbm_ack}, 32'd0);
        tick();
        ram_ack = 0;
        chk("rst_mid_cyc", 32'(ram_cyc), 32'd0);
        chk("rst_mid_stb", 32'(ram_stb), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_still_idle", 32'(ram_cyc), 32'd0);
        tick();
        chk("rst_mid_regrant_cyc", 32'(ram_cyc), 32'd1);
        chk("rst_mid_regrant_d", 32'(ram_addr), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
